// File: rtl/mem_if_pkg.sv
// Shared types for the memory-interface initiator: the buffered request
// record and the initiator FSM states.
package mem_if_pkg;

   localparam int MIF_ADDR_WIDTH = 14;
   localparam int MIF_DATA_WIDTH = 16;
   localparam int MIF_RD_WIDTH   = 8;

   typedef struct packed {
      logic                      write;
      logic [MIF_ADDR_WIDTH-1:0] addr;
      logic [MIF_DATA_WIDTH-1:0] wdata;
   } mem_req_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mif_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO between the client port and the initiator FSM; pointers carry
// an extra wrap bit so full and empty are told apart without a counter.
module mem_req_fifo
   import mem_if_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  mem_req_t din,
   output mem_req_t dout,
   output logic     full,
   output logic     empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   mem_req_t       mem [FIFO_DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/mem_req_initiator.sv
// Memory request initiator: buffers client commands, issues them to the
// memory one at a time, and returns read data or a timeout error.
//
// state | meaning
// IDLE  | no transaction on the memory port; pops the FIFO head when present
// BUSY  | re/we asserted, waiting for mem_resp or the timeout count
module mem_req_initiator
   import mem_if_pkg::*;
#(
   parameter int DATA_WIDTH     = MIF_DATA_WIDTH,
   parameter int RD_WIDTH       = MIF_RD_WIDTH,
   parameter int ADDR_WIDTH     = MIF_ADDR_WIDTH,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  re,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] datafrommif,
   input  logic [RD_WIDTH-1:0]   datatomif,
   input  logic                  mem_resp,
   output logic                  rsp_valid,
   output logic                  rsp_write,
   output logic [RD_WIDTH-1:0]   rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mif_state_e            state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  re_nxt, we_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt;
   logic                  rsp_valid_nxt, rsp_write_nxt, rsp_err_nxt;
   logic [RD_WIDTH-1:0]   rsp_rdata_nxt;

   mem_req_t req_in;
   mem_req_t head;
   logic     fifo_full, fifo_empty, fifo_pop;

   assign req_in    = '{write: req_write, addr: req_addr, wdata: req_wdata};
   assign req_ready = !fifo_full;
   assign busy      = (state != IDLE) || !fifo_empty;

   mem_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_valid && req_ready),
      .pop   (fifo_pop),
      .din   (req_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         re          <= 1'b0;
         we          <= 1'b0;
         addr        <= '0;
         datafrommif <= '0;
         rsp_valid   <= 1'b0;
         rsp_write   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         re          <= re_nxt;
         we          <= we_nxt;
         addr        <= addr_nxt;
         datafrommif <= wdata_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_write   <= rsp_write_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_err     <= rsp_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      re_nxt        = re;
      we_nxt        = we;
      addr_nxt      = addr;
      wdata_nxt     = datafrommif;
      rsp_valid_nxt = 1'b0;
      rsp_write_nxt = rsp_write;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      fifo_pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               addr_nxt  = head.addr;
               if (head.write) wdata_nxt = head.wdata;
               we_nxt    = head.write;
               re_nxt    = !head.write;
               cnt_nxt   = '0;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (mem_resp) begin
               re_nxt        = 1'b0;
               we_nxt        = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_write_nxt = we;
               rsp_err_nxt   = 1'b0;
               rsp_rdata_nxt = we ? '0 : datatomif;
               state_nxt     = IDLE;
            end else if (cnt == CNT_LAST) begin
               re_nxt        = 1'b0;
               we_nxt        = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_write_nxt = we;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
               state_nxt     = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Self-checking bench for mem_req_initiator: directed scenarios plus random
// commands checked against a transaction-level model with a shadow memory.
module tb_mem_req_initiator;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [13:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        re, we;
   logic [13:0] addr;
   logic [15:0] datafrommif;
   logic [7:0]  datatomif = '0;
   logic        mem_resp = 1'b0;
   logic        rsp_valid, rsp_write, rsp_err, busy;
   logic [7:0]  rsp_rdata;

   mem_req_initiator dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .re          (re),
      .we          (we),
      .addr        (addr),
      .datafrommif (datafrommif),
      .datatomif   (datatomif),
      .mem_resp    (mem_resp),
      .rsp_valid   (rsp_valid),
      .rsp_write   (rsp_write),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // model state (main process only)
   bit [15:0] shadow [16384];
   bit        plan [256];
   bit        exp_w [256];
   bit        exp_err [256];
   bit [7:0]  exp_rd [256];
   int        iss_cyc [256];
   int        n_exp = 0, n_rsp = 0, n_iss_m = 0, cyc = 0;
   int        n_chk = 0, n_err = 0;
   int        late_req = 0;
   bit        prev_act = 1'b0, post_reset = 1'b0;

   // responder state (responder process only)
   bit [15:0] rmem [16384];
   bit        act_q = 1'b0;
   int        n_iss = 0, late_done = 0;

   // Memory responder: one-cycle ack on a new request when planned, plus
   // on-demand stray acks to exercise late-ack handling.
   always @(posedge clk) begin
      if (reset) begin
         mem_resp <= 1'b0;
         act_q    <= 1'b0;
      end else begin
         mem_resp <= 1'b0;
         act_q    <= re || we;
         if ((re || we) && !act_q) begin
            if (plan[n_iss]) begin
               mem_resp  <= 1'b1;
               datatomif <= rmem[addr][7:0];
               if (we) rmem[addr] <= datafrommif;
            end
            n_iss <= n_iss + 1;
         end else if (late_req != late_done) begin
            mem_resp  <= 1'b1;
            datatomif <= 8'hA5;
            late_done <= late_done + 1;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_chk++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
      end
   endtask

   task automatic monitor();
      bit act;
      cyc++;
      check_val("re_we_excl", 32'(re && we), 32'd0);
      act = re || we;
      if (act && !prev_act) begin
         iss_cyc[n_iss_m] = cyc;
         n_iss_m++;
      end
      prev_act = act;
      if (rsp_valid) begin
         if (post_reset || n_rsp >= n_exp) begin
            check_val("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            check_val("rsp_write", 32'(rsp_write), 32'(exp_w[n_rsp]));
            check_val("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd[n_rsp]));
            check_val("rsp_err", 32'(rsp_err), 32'(exp_err[n_rsp]));
            check_val("rsp_latency", 32'(cyc - iss_cyc[n_rsp]),
                      exp_err[n_rsp] ? 32'(TIMEOUT) : 32'd2);
            n_rsp++;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (reset) prev_act = 1'b0;
      else monitor();
   endtask

   task automatic push(input logic w, input logic [13:0] a, input logic [15:0] d, input bit ack);
      int g = 0;
      while (!req_ready && g < 500) begin
         tick();
         g++;
      end
      if (!req_ready) check_val("push_ready_wait", 32'(req_ready), 32'd1);
      plan[n_exp]    = ack;
      exp_w[n_exp]   = w;
      exp_err[n_exp] = !ack;
      exp_rd[n_exp]  = (w || !ack) ? 8'h00 : shadow[a][7:0];
      if (w && ack) shadow[a] = d;
      n_exp++;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int g = 0;
      while ((n_rsp < n_exp || busy) && g < budget) begin
         tick();
         g++;
      end
      check_val("drain_rsp_count", 32'(n_rsp), 32'(n_exp));
      check_val("drain_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int k, base, g;
      logic        w;
      logic [13:0] a;
      logic [15:0] d;
      bit          ack;

      tick();
      tick();
      check_val("rst_req_ready", 32'(req_ready), 32'd1);
      check_val("rst_re", 32'(re), 32'd0);
      check_val("rst_we", 32'(we), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_addr", 32'(addr), 32'd0);
      check_val("rst_wdata", 32'(datafrommif), 32'd0);
      check_val("rst_rsp_fields", 32'({rsp_write, rsp_err, rsp_rdata}), 32'd0);
      reset = 1'b0;
      tick();

      // single write
      push(1'b1, 14'h0005, 16'hBEEF, 1'b1);
      check_val("wr_not_yet", 32'(we), 32'd0);
      tick();
      check_val("wr_we", 32'(we), 32'd1);
      check_val("wr_addr", 32'(addr), 32'h0005);
      check_val("wr_data", 32'(datafrommif), 32'hBEEF);
      tick();
      check_val("wr_we_2nd", 32'(we), 32'd1);
      tick();
      check_val("wr_rsp_lat3", 32'(rsp_valid), 32'd1);
      check_val("wr_we_low", 32'(we), 32'd0);
      tick();

      // read back
      base = n_iss_m;
      push(1'b0, 14'h0005, 16'h0000, 1'b1);
      tick();
      check_val("rd_re", 32'(re), 32'd1);
      tick();
      tick();
      check_val("rd_rsp_lat3", 32'(rsp_valid), 32'd1);
      check_val("rd_rdata", 32'(rsp_rdata), 32'h00EF);
      check_val("rd_write", 32'(rsp_write), 32'd0);
      check_val("rd_re_low", 32'(re), 32'd0);
      tick();
      tick();
      check_val("rd_one_issue", 32'(n_iss_m - base), 32'd1);

      // fill the FIFO behind a transaction that never gets acked
      push(1'b0, 14'h0100, 16'h0000, 1'b0);
      tick();
      k = cyc;
      for (int i = 0; i < 4; i++) push(1'b0, 14'(14'h0101 + i), 16'h0000, 1'b0);
      check_val("full_ready_low", 32'(req_ready), 32'd0);
      check_val("full_busy", 32'(busy), 32'd1);
      g = 0;
      while (!req_ready && g < 200) begin
         tick();
         g++;
      end
      check_val("full_release_cycle", 32'(cyc - k), 32'(TIMEOUT + 1));
      push(1'b0, 14'h0105, 16'h0000, 1'b0);
      drain(2000);

      // timeout followed by a late ack
      push(1'b0, 14'h0033, 16'h0000, 1'b0);
      g = 0;
      while (!rsp_valid && g < 200) begin
         tick();
         g++;
      end
      check_val("to_rsp_err", 32'(rsp_err), 32'd1);
      tick();
      late_req++;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("late_ack_no_rsp", 32'(rsp_valid), 32'd0);
         check_val("late_ack_idle", 32'(re || we), 32'd0);
      end

      // back-to-back alternating commands
      base = n_iss_m;
      push(1'b1, 14'h0010, 16'h1234, 1'b1);
      push(1'b0, 14'h0010, 16'h0000, 1'b1);
      push(1'b1, 14'h0011, 16'h5678, 1'b1);
      drain(500);
      check_val("b2b_period_1", 32'(iss_cyc[base+1] - iss_cyc[base]), 32'd3);
      check_val("b2b_period_2", 32'(iss_cyc[base+2] - iss_cyc[base+1]), 32'd3);

      // random traffic
      for (int i = 0; i < 40; i++) begin
         w   = 1'($urandom_range(0, 1));
         a   = 14'($urandom_range(0, 7));
         d   = 16'($urandom);
         ack = ($urandom_range(0, 7) != 0);
         push(w, a, d, ack);
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
      end
      drain(3000);

      // reset while a write is outstanding and the FIFO holds more
      push(1'b1, 14'h0020, 16'hAAAA, 1'b0);
      push(1'b0, 14'h0021, 16'h0000, 1'b0);
      push(1'b1, 14'h0022, 16'h5555, 1'b0);
      check_val("rstb_we_before", 32'(we), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_val("rstb_we_async", 32'(we), 32'd0);
      check_val("rstb_busy", 32'(busy), 32'd0);
      check_val("rstb_ready", 32'(req_ready), 32'd1);
      tick();
      tick();
      reset = 1'b0;
      post_reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val("rstb_no_issue", 32'(re || we), 32'd0);
         check_val("rstb_no_rsp", 32'(rsp_valid), 32'd0);
      end
      check_val("rstb_busy_after", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
